// File: rtl/rr_mux_nt1_if.sv
// Handshake bundle for rr_mux_nt1: N producer channels in, one registered beat out.
// LAST_IN exists only when RR_MUX_LOCK_EN is defined.
interface rr_mux_nt1_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] d_in;
    logic [N-1:0]       valid_in;
    logic [N-1:0]       ready_out;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [SELW-1:0]    grant_idx;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]       last_in;

    modport master (output d_in, valid_in, mode, sel, dout_ready, last_in,
                    input  ready_out, dout, dout_valid, grant_idx);
    modport slave  (input  d_in, valid_in, mode, sel, dout_ready, last_in,
                    output ready_out, dout, dout_valid, grant_idx);
`else
    modport master (output d_in, valid_in, mode, sel, dout_ready,
                    input  ready_out, dout, dout_valid, grant_idx);
    modport slave  (input  d_in, valid_in, mode, sel, dout_ready,
                    output ready_out, dout, dout_valid, grant_idx);
`endif
endinterface

// File: rtl/rr_mux_nt1.sv
// N:1 valid/ready mux with one full-throughput output register; fixed-select or round-robin.
// Define RR_MUX_LOCK_EN to hold a round-robin grant across a multi-beat packet (LAST_IN).
module rr_mux_nt1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    rr_mux_nt1_if.slave bus
);
    logic [WIDTH-1:0] chan [N];
    logic [SELW-1:0]  last, cand, rr_idx;
    logic             cand_vld, load, xfer;
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;
    logic [SELW-1:0]  gi_q;
`ifdef RR_MUX_LOCK_EN
    logic             locked;
    logic [SELW-1:0]  lock_ch;
`endif

    assign load = !dv_q || bus.dout_ready;
    assign xfer = load && cand_vld;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            assign chan[i]          = bus.d_in[i*WIDTH +: WIDTH];
            assign bus.ready_out[i] = !rst && xfer && (cand == SELW'(i));
        end
    endgenerate

    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        rr_idx   = '0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                cand_vld = bus.valid_in[bus.sel];
                cand     = bus.sel;
            end
`ifdef RR_MUX_LOCK_EN
        end else if (locked) begin
            // Locked grant waits on its own channel even if it drops valid
            cand_vld = bus.valid_in[lock_ch];
            cand     = lock_ch;
`endif
        end else begin
            // Scan downward so the channel nearest after 'last' wins
            for (int k = N; k >= 1; k--) begin
                rr_idx = SELW'((int'(last) + k) % N);
                if (bus.valid_in[rr_idx]) begin
                    cand_vld = 1'b1;
                    cand     = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            gi_q   <= '0;
            last   <= SELW'(N-1);
`ifdef RR_MUX_LOCK_EN
            locked  <= 1'b0;
            lock_ch <= '0;
`endif
        end else begin
            if (load) begin
                dv_q <= cand_vld;
                if (cand_vld) begin
                    dout_q <= chan[cand];
                    gi_q   <= cand;
                end
            end
`ifdef RR_MUX_LOCK_EN
            if (!bus.mode) begin
                locked <= 1'b0;
            end else if (xfer) begin
                if (bus.last_in[cand]) begin
                    locked <= 1'b0;
                    last   <= cand;
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= cand;
                end
            end
`else
            if (xfer && bus.mode) last <= cand;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.grant_idx  = gi_q;
endmodule

// File: doc/rr_mux_nt1.md
Name: rr_mux_nt1

Overview:
- Parametrised successor to the 32-bit 2:1 data mux: N input channels of WIDTH bits feed one registered output channel.
- Every channel uses a valid/ready handshake.
- Two select modes:
  - fixed mode: SEL picks the channel, like the combinational mux.
  - round-robin mode: an internal arbiter picks among valid channels.
- Used where several producers share one datapath sink, e.g. writeback or bus-request funnelling.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), width of SEL and GRANT_IDX (derived; do not override).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- D_IN  in  N*WIDTH  channel data, flattened; channel i occupies [i*WIDTH +: WIDTH].
- VALID_IN  in  N  per-channel valid.
- READY_OUT  out  N  per-channel ready, combinational.
- MODE  in  1  0 = fixed select, 1 = round-robin.
- SEL  in  SELW  channel index used when MODE=0.
- DOUT  out  WIDTH  registered output data.
- DOUT_VALID  out  1  output register holds a beat.
- DOUT_READY  in  1  sink accepts the beat.
- GRANT_IDX  out  SELW  registered index of the channel that supplied DOUT.

Behaviour:
- Reset (asynchronous, immediate on RST=1):
  - DOUT=0, DOUT_VALID=0, GRANT_IDX=0.
  - Round-robin pointer last=N-1, so channel 0 has first priority.
  - All READY_OUT=0 while RST=1.
- Definitions:
  - load = !DOUT_VALID || DOUT_READY.
  - The output register acts as a single pipeline stage with full throughput: one beat per cycle when the sink is always ready.
- Candidate selection (combinational), result cand or none:
  - MODE=0:
    - cand = SEL when SEL<N and VALID_IN[SEL]=1.
    - none when SEL>=N or the selected channel is not valid.
    - Other channels never see ready.
  - MODE=1: cand = first i with VALID_IN[i]=1, scanning (last+1) mod N upward with wrap.
- Handshake:
  - READY_OUT[i] = load && (cand==i); at most one bit set.
  - A beat transfers when VALID_IN[i] && READY_OUT[i].
- Clock edge:
  - On transfer: DOUT<=D_IN[cand], GRANT_IDX<=cand, DOUT_VALID<=1. In MODE=1 only, last<=cand.
  - On load with no transfer: DOUT_VALID<=0. DOUT and GRANT_IDX hold their previous values.
  - When !load (stall): DOUT, DOUT_VALID and GRANT_IDX are held stable.
- Latency: 1 cycle from input transfer to DOUT_VALID.
- Producers must hold VALID_IN and data stable until their transfer completes; the block does not check this.
- MODE or SEL change: takes effect in the same cycle's selection and does not disturb a beat already in the output register. The pointer is not updated in MODE=0.
- All channels idle in MODE=1: no transfer, pointer unchanged.
- N=2, MODE=0, DOUT_READY tied 1: behaves as the old mux delayed by one cycle.

Optional Feature:
- Macro: RR_MUX_LOCK_EN.
- When defined:
  - Adds input port LAST_IN (N bits, per-channel end-of-packet).
  - In MODE=1, once a channel transfers a beat with LAST_IN=0, the grant locks to that channel. Other channels get no ready, even if the locked channel drops valid.
  - The lock releases after its beat with LAST_IN=1 transfers; the pointer updates only at that release.
  - MODE=0 ignores the lock.
  - Switching MODE from 1 to 0 clears the lock.
  - RST clears the lock.
- When undefined: no LAST_IN port; arbitration is per beat as described above.

Test Plan:
- Reset: assert RST mid-stream with DOUT_VALID=1 -> DOUT=0, DOUT_VALID=0, GRANT_IDX=0 immediately, without waiting for a clock edge.
- Fixed mode, N=4, WIDTH=32:
  - Stimulus: D_IN ch2=32'hdeadbeef, ch1=32'hfeedfeed, all valid, SEL=2, DOUT_READY=1.
  - Response: next cycle DOUT=32'hdeadbeef, GRANT_IDX=2, READY_OUT=4'b0100.
  - Then SEL=1 -> DOUT=32'hfeedfeed, GRANT_IDX=1.
- Round-robin fairness: all 4 channels valid continuously, DOUT_READY=1 -> GRANT_IDX sequence 0,1,2,3,0,1; one beat per cycle.
- Backpressure:
  - DOUT_READY=0 for 3 cycles while holding 32'hbeeeeeef -> DOUT and GRANT_IDX stable, READY_OUT=0.
  - On release, the next beat loads the same cycle; no beat is lost or duplicated (scoreboard).
- Boundaries:
  - SEL=3 with only ch0 valid in MODE=0 -> no ready, DOUT_VALID falls after the drain.
  - MODE=1 with only ch3 valid and last=3 -> wrap-around grants ch3.
- Lock (RR_MUX_LOCK_EN): ch1 sends 3 beats (LAST on the third) while ch0 and ch2 are valid -> GRANT_IDX 1,1,1 then 2.
